// File: rtl/u_ex_stage.sv
// ----------------------------------------------------------------------------
// u_ex_stage -- execute-stage pipeline slice of the RV32I core.
//
// Accepts a decoded instruction from decode (in_valid/in_ready), applies
// writeback forwarding to both source operands, selects the u_alu operands,
// registers the ALU result into the EX/MEM register (out_valid/out_ready),
// and resolves branches/jumps into a single-cycle fetch redirect.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_*                decoded instruction + handshake from decode
//   flush               squash EX/MEM contents and block accept
//   fwd_we/rd/data      writeback forwarding source
//   alu_op/i1/i2        combinational drive to u_alu
//   alu_o               result from u_alu
//   out_*               EX/MEM register + handshake to MEM
//   redirect_valid/pc   one-cycle fetch redirect
// ----------------------------------------------------------------------------
module u_ex_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic [3:0]  in_alu_op,
    input  logic        in_sel_i1,
    input  logic        in_sel_i2,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_we,
    input  logic [2:0]  in_br_type,

    input  logic        flush,

    input  logic        fwd_we,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data,

    output logic [3:0]  alu_op,
    output logic [31:0] alu_i1,
    output logic [31:0] alu_i2,
    input  logic [31:0] alu_o,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,

    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_BLTU = 3'b101,
        BR_BGEU = 3'b110,
        BR_JUMP = 3'b111
    } br_type_e;

    logic [31:0] op1;
    logic [31:0] op2;
    br_type_e    br_type;
    logic        is_jump;
    logic        cmp_eq;
    logic        cmp_lt;
    logic        cmp_ltu;
    logic        taken;
    logic        accept;

    logic        out_valid_q,      out_valid_d;
    logic [31:0] out_result_q,     out_result_d;
    logic [31:0] out_store_data_q, out_store_data_d;
    logic [4:0]  out_rd_q,         out_rd_d;
    logic        out_rd_we_q,      out_rd_we_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q,    redirect_pc_d;

    // Writeback forwarding; x0 is hard-wired zero and never forwarded.
    always_comb begin
        op1 = in_rs1_data;
        op2 = in_rs2_data;
        if (fwd_we && (fwd_rd == in_rs1) && (in_rs1 != 5'd0)) op1 = fwd_data;
        if (fwd_we && (fwd_rd == in_rs2) && (in_rs2 != 5'd0)) op2 = fwd_data;
    end

    // ALU drive is unconditional so u_alu sees a stable input every cycle.
    assign alu_op = in_alu_op;
    assign alu_i1 = in_sel_i1 ? in_pc  : op1;
    assign alu_i2 = in_sel_i2 ? in_imm : op2;

    // Branch compare runs on the forwarded operands, not on the ALU inputs,
    // since branches use the ALU to compute the target (pc+imm).
    assign br_type = br_type_e'(in_br_type);
    assign is_jump = (br_type == BR_JUMP);
    assign cmp_eq  = (op1 == op2);
    assign cmp_lt  = ($signed(op1) < $signed(op2));
    assign cmp_ltu = (op1 < op2);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = cmp_eq;
            BR_BNE:  taken = !cmp_eq;
            BR_BLT:  taken = cmp_lt;
            BR_BGE:  taken = !cmp_lt;
            BR_BLTU: taken = cmp_ltu;
            BR_BGEU: taken = !cmp_ltu;
            BR_JUMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // EX/MEM next state: flush > accept > drain > hold.
    always_comb begin
        out_valid_d      = out_valid_q;
        out_result_d     = out_result_q;
        out_store_data_d = out_store_data_q;
        out_rd_d         = out_rd_q;
        out_rd_we_d      = out_rd_we_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d      = 1'b1;
            out_result_d     = is_jump ? (in_pc + 32'd4) : alu_o;
            out_store_data_d = op2;
            out_rd_d         = in_rd;
            // Conditional branches never write rd; jumps write the link.
            out_rd_we_d      = in_rd_we && ((br_type == BR_NONE) || is_jump);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Redirect pulses only on the accepting cycle, so backpressure on the
    // EX/MEM register cannot stretch it.
    always_comb begin
        redirect_valid_d = accept && taken;
        redirect_pc_d    = redirect_pc_q;
        if (accept && taken) begin
            redirect_pc_d = is_jump ? {alu_o[31:1], 1'b0} : alu_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_result_q     <= '0;
            out_store_data_q <= '0;
            out_rd_q         <= '0;
            out_rd_we_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= RESET_PC;
        end else begin
            out_valid_q      <= out_valid_d;
            out_result_q     <= out_result_d;
            out_store_data_q <= out_store_data_d;
            out_rd_q         <= out_rd_d;
            out_rd_we_q      <= out_rd_we_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_store_data = out_store_data_q;
    assign out_rd         = out_rd_q;
    assign out_rd_we      = out_rd_we_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_u_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_u_ex_stage -- directed testbench for u_ex_stage.
//
// A small behavioural ALU (0: add, 1: sub) closes the alu_i1/alu_i2 -> alu_o
// loop. Inputs change 1ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_u_ex_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic [3:0]  in_alu_op;
    logic        in_sel_i1;
    logic        in_sel_i2;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [2:0]  in_br_type;
    logic        flush;
    logic        fwd_we;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [3:0]  alu_op;
    logic [31:0] alu_i1;
    logic [31:0] alu_i2;
    logic [31:0] alu_o;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    u_ex_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_imm         (in_imm),
        .in_alu_op      (in_alu_op),
        .in_sel_i1      (in_sel_i1),
        .in_sel_i2      (in_sel_i2),
        .in_rd          (in_rd),
        .in_rd_we       (in_rd_we),
        .in_br_type     (in_br_type),
        .flush          (flush),
        .fwd_we         (fwd_we),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .alu_op         (alu_op),
        .alu_i1         (alu_i1),
        .alu_i2         (alu_i2),
        .alu_o          (alu_o),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_rd_we      (out_rd_we),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for u_alu.
    always_comb begin
        alu_o = '0;
        case (alu_op)
            4'd0:    alu_o = alu_i1 + alu_i2;
            4'd1:    alu_o = alu_i1 - alu_i2;
            default: alu_o = '0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                         input logic [3:0] op, input logic s1, input logic s2,
                         input logic [4:0] rd, input logic we, input logic [2:0] br);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_rs1_data = rs1d;
        in_rs2_data = rs2d;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        in_alu_op   = op;
        in_sel_i1   = s1;
        in_sel_i2   = s2;
        in_rd       = rd;
        in_rd_we    = we;
        in_br_type  = br;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        fwd_we = 1'b0; fwd_rd = '0; fwd_data = '0;
        in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_alu_op = '0; in_sel_i1 = 1'b0; in_sel_i2 = 1'b0;
        in_rd = '0; in_rd_we = 1'b0; in_br_type = '0;

        // Reset state
        tick();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_redir_valid", 32'(redirect_valid), 32'd0);
        check_eq("rst_redir_pc", redirect_pc, RST_PC);
        check_eq("rst_out_result", out_result, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);

        // ADD 5+7
        drive(32'h0, 32'd5, 32'd7, 5'd1, 5'd2, 32'h0, 4'd0, 1'b0, 1'b0, 5'd5, 1'b1, 3'b000);
        #1;
        check_eq("add_alu_i1", alu_i1, 32'd5);
        check_eq("add_alu_i2", alu_i2, 32'd7);
        check_eq("add_alu_op", 32'(alu_op), 32'd0);
        tick();
        check_eq("add_out_valid", 32'(out_valid), 32'd1);
        check_eq("add_out_result", out_result, 32'd12);
        check_eq("add_out_rd_we", 32'(out_rd_we), 32'd1);
        check_eq("add_out_rd", 32'(out_rd), 32'd5);
        check_eq("add_store_data", out_store_data, 32'd7);

        // SUB with rs1 forwarded from writeback
        drive(32'h0, 32'h999, 32'h10, 5'd3, 5'd4, 32'h0, 4'd1, 1'b0, 1'b0, 5'd6, 1'b1, 3'b000);
        fwd_we = 1'b1; fwd_rd = 5'd3; fwd_data = 32'h100;
        #1;
        check_eq("fwd_alu_i1", alu_i1, 32'h100);
        tick();
        check_eq("fwd_out_valid", 32'(out_valid), 32'd1);
        check_eq("fwd_out_result", out_result, 32'hF0);

        // x0 must not be forwarded
        drive(32'h0, 32'h50, 32'h10, 5'd0, 5'd4, 32'h0, 4'd1, 1'b0, 1'b0, 5'd6, 1'b1, 3'b000);
        fwd_rd = 5'd0;
        #1;
        check_eq("x0_alu_i1", alu_i1, 32'h50);
        tick();
        check_eq("x0_out_result", out_result, 32'h40);

        // rs2 forwarded to store data while ALU uses imm
        drive(32'h0, 32'h200, 32'h10, 5'd1, 5'd4, 32'h8, 4'd0, 1'b0, 1'b1, 5'd0, 1'b0, 3'b000);
        fwd_rd = 5'd4; fwd_data = 32'h33;
        #1;
        check_eq("fwd2_alu_i2", alu_i2, 32'h8);
        tick();
        check_eq("fwd2_out_result", out_result, 32'h208);
        check_eq("fwd2_store_data", out_store_data, 32'h33);
        fwd_we = 1'b0;

        // BLT taken: -1 < 1 signed, target pc+imm
        drive(32'h40, 32'hFFFF_FFFF, 32'd1, 5'd1, 5'd2, 32'h20, 4'd0, 1'b1, 1'b1, 5'd7, 1'b1, 3'b011);
        tick();
        check_eq("blt_redir_valid", 32'(redirect_valid), 32'd1);
        check_eq("blt_redir_pc", redirect_pc, 32'h60);
        check_eq("blt_out_rd_we", 32'(out_rd_we), 32'd0);

        // BLTU not taken: 0xFFFFFFFF > 1 unsigned
        drive(32'h80, 32'hFFFF_FFFF, 32'd1, 5'd1, 5'd2, 32'h20, 4'd0, 1'b1, 1'b1, 5'd7, 1'b1, 3'b101);
        tick();
        check_eq("bltu_redir_valid", 32'(redirect_valid), 32'd0);
        check_eq("bltu_redir_pc_hold", redirect_pc, 32'h60);
        check_eq("bltu_out_result", out_result, 32'hA0);

        // Idle cycle drains EX/MEM
        in_valid = 1'b0;
        tick();
        check_eq("drain_out_valid", 32'(out_valid), 32'd0);

        // JUMP: target (rs1+imm) with bit 0 cleared, link pc+4
        drive(32'h1000, 32'h2001, 32'd0, 5'd1, 5'd2, 32'h4, 4'd0, 1'b0, 1'b1, 5'd1, 1'b1, 3'b111);
        tick();
        check_eq("jal_redir_valid", 32'(redirect_valid), 32'd1);
        check_eq("jal_redir_pc", redirect_pc, 32'h2004);
        check_eq("jal_out_result", out_result, 32'h1004);
        check_eq("jal_out_rd_we", 32'(out_rd_we), 32'd1);

        // JUMP from top of address space: pc+4 wraps to 0
        drive(32'hFFFF_FFFC, 32'h10, 32'd0, 5'd1, 5'd2, 32'h0, 4'd0, 1'b0, 1'b1, 5'd1, 1'b1, 3'b111);
        tick();
        check_eq("wrap_out_result", out_result, 32'h0);
        check_eq("wrap_redir_pc", redirect_pc, 32'h10);
        check_eq("wrap_redir_valid", 32'(redirect_valid), 32'd1);

        // Backpressure for 3 cycles with a pending instruction
        out_ready = 1'b0;
        drive(32'h0, 32'd1, 32'd2, 5'd1, 5'd2, 32'h0, 4'd0, 1'b0, 1'b0, 5'd9, 1'b1, 3'b000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            check_eq("stall_out_valid", 32'(out_valid), 32'd1);
            check_eq("stall_out_result", out_result, 32'h0);
            check_eq("stall_out_rd", 32'(out_rd), 32'd1);
            check_eq("stall_redir_valid", 32'(redirect_valid), 32'd0);
        end

        // Release: drain and accept in the same cycle, then back-to-back
        out_ready = 1'b1;
        #1;
        check_eq("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check_eq("b2b1_out_valid", 32'(out_valid), 32'd1);
        check_eq("b2b1_out_result", out_result, 32'd3);
        check_eq("b2b1_out_rd", 32'(out_rd), 32'd9);
        drive(32'h0, 32'd10, 32'd20, 5'd1, 5'd2, 32'h0, 4'd0, 1'b0, 1'b0, 5'd10, 1'b1, 3'b000);
        tick();
        check_eq("b2b2_out_valid", 32'(out_valid), 32'd1);
        check_eq("b2b2_out_result", out_result, 32'd30);

        // Flush while holding a valid entry and offering a jump
        flush = 1'b1;
        drive(32'h200, 32'h400, 32'd0, 5'd1, 5'd2, 32'h0, 4'd0, 1'b0, 1'b1, 5'd1, 1'b1, 3'b111);
        #1;
        check_eq("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_redir_valid", 32'(redirect_valid), 32'd0);
        check_eq("flush_redir_pc_hold", redirect_pc, 32'h10);
        flush = 1'b0;

        // Async reset in the middle of a stall
        drive(32'h80, 32'h300, 32'd0, 5'd1, 5'd2, 32'h0, 4'd0, 1'b0, 1'b1, 5'd1, 1'b1, 3'b111);
        tick();
        check_eq("pre_rst_redir_pc", redirect_pc, 32'h300);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst_redir_valid", 32'(redirect_valid), 32'd0);
        check_eq("async_rst_redir_pc", redirect_pc, RST_PC);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/u_ex_stage.md
Name: u_ex_stage

Overview:
Execute-stage pipeline slice of the RV32I core, sitting directly upstream of the u_alu instance.
- Accepts a decoded instruction from decode over a valid/ready handshake.
- Applies writeback forwarding and selects the ALU operands.
- Drives u_alu combinationally and registers its result into the EX/MEM register.
- Resolves branches and jumps, and issues a one-cycle fetch redirect.

Parameters:
RESET_PC, 32'h0000_0000, value loaded into redirect_pc at reset.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decode has an instruction
in_ready  output  1  EX can accept this cycle
in_pc  input  32  instruction PC
in_rs1_data  input  32  register-file rs1 value
in_rs2_data  input  32  register-file rs2 value
in_rs1  input  5  rs1 index (for forwarding)
in_rs2  input  5  rs2 index (for forwarding)
in_imm  input  32  sign-extended immediate
in_alu_op  input  4  ALU opcode, passed to u_alu unchanged
in_sel_i1  input  1  0: alu_i1=rs1, 1: alu_i1=pc
in_sel_i2  input  1  0: alu_i2=rs2, 1: alu_i2=imm
in_rd  input  5  destination register
in_rd_we  input  1  destination write enable
in_br_type  input  3  000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu, 111 jump
flush  input  1  squash EX/MEM contents and block accept
fwd_we  input  1  writeback forwarding valid
fwd_rd  input  5  writeback destination
fwd_data  input  32  writeback data
alu_op  output  4  to u_alu
alu_i1  output  32  to u_alu
alu_i2  output  32  to u_alu
alu_o  input  32  from u_alu
out_valid  output  1  EX/MEM register holds an instruction
out_ready  input  1  MEM stage accepts
out_result  output  32  ALU result, or pc+4 for jumps
out_store_data  output  32  forwarded rs2
out_rd  output  5  destination
out_rd_we  output  1  destination write enable
redirect_valid  output  1  one-cycle fetch redirect
redirect_pc  output  32  redirect target

Behaviour:
Reset:
- When rst_n is low: out_valid=0, redirect_valid=0, redirect_pc=RESET_PC, and all other registered outputs 0.
- in_ready=1 once reset is released.

Forwarding (combinational):
- op1 = fwd_data if fwd_we && fwd_rd==in_rs1 && in_rs1!=0; otherwise in_rs1_data.
- op2 uses the same rule with in_rs2.
- x0 is never forwarded.

ALU drive (combinational):
- alu_op = in_alu_op.
- alu_i1 = in_sel_i1 ? in_pc : op1.
- alu_i2 = in_sel_i2 ? in_imm : op2.
- Driven every cycle regardless of in_valid.

Branch compare:
- Computed locally on op1/op2, independent of the ALU.
- eq: op1==op2. lt: signed op1<op2. ltu: unsigned op1<op2.
- taken: beq=eq, bne=!eq, blt=lt, bge=!lt, bltu=ltu, bgeu=!ltu, jump=1, none=0.

Handshake:
- in_ready = !flush && (!out_valid || out_ready).
- accept = in_valid && in_ready.

EX/MEM register update, in priority order:
- flush: out_valid<=0. Other fields are don't-care.
- accept: out_valid<=1.
  - out_result <= (br_type==jump) ? in_pc+4 : alu_o.
  - out_store_data <= op2.
  - out_rd <= in_rd.
  - out_rd_we <= in_rd_we && (br_type is none or jump).
- out_valid && out_ready with no accept: out_valid<=0.
- Otherwise: hold all fields.

Latency: one cycle from accept to out_valid.

Redirect:
- On accept with taken: redirect_valid<=1 and redirect_pc<=alu_o, with bit 0 cleared for jump.
- Otherwise redirect_valid<=0.
- redirect_valid is a pulse of exactly one cycle, even if out_valid is then held by backpressure.
- redirect_pc holds its last value.
- flush in the same cycle suppresses the pulse, since no accept occurs.

Boundary rules:
- Stall: out_valid=1 and out_ready=0 means in_ready=0 and all EX/MEM fields are stable.
- Simultaneous drain and accept: out_valid stays 1 and the new data loads. Throughput is one instruction per cycle.
- Reset asserted mid-operation immediately clears out_valid and redirect_valid, with no wait for the clock.
- Arithmetic: pc+4 wraps modulo 2^32. No exceptions are raised; misaligned targets are passed through.

Test Plan:
- ADD: in_rs1_data=5, in_rs2_data=7, alu_op=0000, sel=0/0 -> alu_i1=5, alu_i2=7; next cycle out_valid=1, out_result=12, out_rd_we=1.
- Forwarding: in_rs1=3, fwd_we=1, fwd_rd=3, fwd_data=0x100, SUB with rs2=0x10 -> alu_i1=0x100, out_result=0xF0. Repeat with in_rs1=0, fwd_rd=0 -> no forwarding applied.
- Branch: blt, op1=0xFFFF_FFFF, op2=1, sel_i1=pc, sel_i2=imm, pc=0x40, imm=0x20 -> redirect_valid pulses one cycle, redirect_pc=0x60, out_rd_we=0. Same operands with bltu -> no redirect.
- Jump: pc=0x1000, rs1=0x2001, sel_i1=0, imm=4 -> redirect_pc=0x2004, out_result=0x1004, out_rd_we=1.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 and EX/MEM stable. out_ready=1 with in_valid=1 -> back-to-back transfer with no bubble.
- Flush/reset: flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, no redirect. rst_n low mid-stall -> out_valid=0 asynchronously, redirect_pc=RESET_PC.
